// File: rtl/prbs_frame_checker_if.sv
// Handshake bundle between a PRBS source and prbs_frame_checker.
// Define PRBS_CHK_FIRST_ERR_EN to carry the first-error index fields.
interface prbs_frame_checker_if #(
    parameter int LFSR_W = 15,
    parameter int CNT_W  = 16
);
    logic              load;
    logic              seed_sel;
    logic [LFSR_W-1:0] seed;
    logic              en;
    logic              din;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  bit_cnt;
`ifdef PRBS_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0]  first_err_idx;
    logic              first_err_vld;

    modport master (
        output load, seed_sel, seed, en, din,
        input  busy, done, pass, err_cnt, bit_cnt,
        input  first_err_idx, first_err_vld
    );
    modport slave (
        input  load, seed_sel, seed, en, din,
        output busy, done, pass, err_cnt, bit_cnt,
        output first_err_idx, first_err_vld
    );
`else
    modport master (
        output load, seed_sel, seed, en, din,
        input  busy, done, pass, err_cnt, bit_cnt
    );
    modport slave (
        input  load, seed_sel, seed, en, din,
        output busy, done, pass, err_cnt, bit_cnt
    );
`endif
endinterface

// File: rtl/prbs_frame_checker.sv
// Frame-based PRBS checker: reference LFSR vs serial din, counts mismatches.
// Define PRBS_CHK_FIRST_ERR_EN to latch the index of the first mismatch.
module prbs_frame_checker #(
    parameter int              LFSR_W    = 15,
    parameter int              TAP_A     = 14,
    parameter int              TAP_B     = 15,
    parameter logic [LFSR_W-1:0] SEED_DEF = 15'h3715,
    parameter int              FRAME_LEN = 96,
    parameter int              CNT_W     = 16
) (
    input logic               clk,
    input logic               reset_N,
    prbs_frame_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_LEN);

    state_e           state_q, state_d;
    logic [LFSR_W:1]  lfsr_q, lfsr_d;
    logic [LFSR_W:1]  seed_r, def_r;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             exp_bit;
    logic             mis;
`ifdef PRBS_CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic             fvld_q, fvld_d;
`endif

    // lfsr bit k holds stage rk; seed MSB lands in r1
    always_comb begin
        seed_r = '0;
        def_r  = '0;
        for (int k = 1; k <= LFSR_W; k++) begin
            def_r[k]  = SEED_DEF[LFSR_W-k];
            seed_r[k] = bus.seed_sel ? bus.seed[LFSR_W-k]
                                     : SEED_DEF[LFSR_W-k];
        end
    end

    assign exp_bit = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
    assign mis     = bus.din ^ exp_bit;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        err_d   = err_q;
        bit_d   = bit_q;
        done_d  = done_q;
        pass_d  = pass_q;
`ifdef PRBS_CHK_FIRST_ERR_EN
        fidx_d  = fidx_q;
        fvld_d  = fvld_q;
`endif
        if (bus.load) begin
            state_d = CHECK;
            lfsr_d  = seed_r;
            err_d   = '0;
            bit_d   = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
`ifdef PRBS_CHK_FIRST_ERR_EN
            fidx_d  = '0;
            fvld_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                CHECK: begin
                    if (bus.en) begin
                        lfsr_d = {lfsr_q[LFSR_W-1:1], exp_bit};
                        bit_d  = bit_q + 1'b1;
                        if (mis && (err_q != '1)) begin
                            err_d = err_q + 1'b1;
                        end
`ifdef PRBS_CHK_FIRST_ERR_EN
                        if (mis && !fvld_q) begin
                            fidx_d = bit_q;
                            fvld_d = 1'b1;
                        end
`endif
                        if (bit_d == FRAME_C) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                        end
                    end
                end
                IDLE, DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= IDLE;
            lfsr_q  <= def_r;
            err_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            err_q   <= err_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef PRBS_CHK_FIRST_ERR_EN
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            fidx_q <= '0;
            fvld_q <= 1'b0;
        end else begin
            fidx_q <= fidx_d;
            fvld_q <= fvld_d;
        end
    end

    assign bus.first_err_idx = fidx_q;
    assign bus.first_err_vld = fvld_q;
`endif

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
    assign bus.bit_cnt = bit_q;

endmodule
